pwm_spi_sequencer: RTL

PWM_SPI_SEQUENCER -- requirements
Module: pwm_spi_sequencer

---
 rtl/pwm_spi_sequencer.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_spi_sequencer.sv
// Two-requester round-robin sequencer driving 16-bit mode-0 SPI frames to a PWM driver.
// Define PWM_SPI_SEQUENCER_READBACK_EN to enable reads over miso; otherwise reads complete with err.
module pwm_spi_sequencer #(
    parameter int HALF_PERIOD = 4,
    parameter int CS_GAP      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_req,
    input  logic       a_rd,
    input  logic [2:0] a_addr,
    input  logic [7:0] a_wdata,
    output logic       a_ack,
    input  logic       b_req,
    input  logic       b_rd,
    input  logic [2:0] b_addr,
    input  logic [7:0] b_wdata,
    output logic       b_ack,
    output logic       done,
    output logic       done_id,
    output logic       err,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       sclk,
    output logic       cs,
    output logic       mosi,
    input  logic       miso
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [7:0] HP_LAST  = 8'(HALF_PERIOD - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] sh_q, sh_d;
    logic [7:0]  rx_q, rx_d;
    logic        rd_q, rd_d;
    logic        cur_q, cur_d;
    logic        last_q, last_d;
    logic        err_pend_q, err_pend_d;
    logic        a_ack_q, a_ack_d;
    logic        b_ack_q, b_ack_d;
    logic        done_q, done_d;
    logic        done_id_q, done_id_d;
    logic        err_q, err_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        sclk_q, sclk_d;
    logic        cs_q, cs_d;
    logic        mosi_q, mosi_d;

    logic        gnt_b_s;
    logic        sel_rd_s;
    logic [2:0]  sel_addr_s;
    logic [7:0]  sel_wdata_s;
    logic [15:0] frame_s;
    logic        bad_s;

    // Round-robin pick (last_q=1 means B went last, so A wins a tie) and frame assembly.
    always_comb begin
        gnt_b_s = b_req & (~a_req | ~last_q);
        if (gnt_b_s) begin
            sel_rd_s    = b_rd;
            sel_addr_s  = b_addr;
            sel_wdata_s = b_wdata;
        end else begin
            sel_rd_s    = a_rd;
            sel_addr_s  = a_addr;
            sel_wdata_s = a_wdata;
        end
        frame_s = sel_rd_s ? {5'b00000, sel_addr_s, 8'h00}
                           : {1'b1, 4'b0000, sel_addr_s, sel_wdata_s};
`ifdef PWM_SPI_SEQUENCER_READBACK_EN
        bad_s = (sel_addr_s == 3'd7);
`else
        bad_s = (sel_addr_s == 3'd7) | sel_rd_s;
`endif
    end

    // Next-state and next-output computation for the sequencer FSM.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        rx_d       = rx_q;
        rd_d       = rd_q;
        cur_d      = cur_q;
        last_d     = last_q;
        err_pend_d = err_pend_q;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        done_d     = 1'b0;
        done_id_d  = done_id_q;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        sclk_d     = sclk_q;
        cs_d       = cs_q;
        mosi_d     = mosi_q;
        case (state_q)
            IDLE: begin
                if (a_req | b_req) begin
                    a_ack_d = ~gnt_b_s;
                    b_ack_d = gnt_b_s;
                    last_d  = gnt_b_s;
                    cur_d   = gnt_b_s;
                    rd_d    = sel_rd_s;
                    div_d   = 8'd0;
                    bit_d   = 4'd0;
                    rx_d    = 8'h00;
                    if (bad_s) begin
                        // Rejected requests skip the bus; done+err comes from GAP.
                        err_pend_d = 1'b1;
                        state_d    = GAP;
                    end else begin
                        cs_d    = 1'b0;
                        sclk_d  = 1'b0;
                        mosi_d  = frame_s[15];
                        sh_d    = {frame_s[14:0], 1'b0};
                        state_d = SETUP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (div_q == HP_LAST) begin
                    div_d   = 8'd0;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SHIFT: begin
                if (div_q != HP_LAST) begin
                    div_d = div_q + 8'd1;
                end else if (!sclk_q) begin
                    div_d  = 8'd0;
                    sclk_d = 1'b1;
                    if (rd_q && bit_q[3]) begin
                        rx_d = {miso, rx_q[7:1]};
                    end else begin
                        rx_d = rx_q;
                    end
                end else begin
                    div_d  = 8'd0;
                    sclk_d = 1'b0;
                    mosi_d = sh_q[15];
                    sh_d   = {sh_q[14:0], 1'b0};
                    if (bit_q == 4'd15) begin
                        state_d = HOLD;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            HOLD: begin
                if (div_q == HP_LAST) begin
                    div_d     = 8'd0;
                    cs_d      = 1'b1;
                    done_d    = 1'b1;
                    done_id_d = cur_q;
                    if (rd_q) begin
                        rdata_d = rx_q;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    state_d = GAP;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            GAP: begin
                if (err_pend_q) begin
                    err_pend_d = 1'b0;
                    done_d     = 1'b1;
                    err_d      = 1'b1;
                    done_id_d  = cur_q;
                end else begin
                    err_pend_d = 1'b0;
                end
                if (div_q == GAP_LAST) begin
                    div_d   = 8'd0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            div_q      <= 8'd0;
            bit_q      <= 4'd0;
            sh_q       <= 16'h0000;
            rx_q       <= 8'h00;
            rd_q       <= 1'b0;
            cur_q      <= 1'b0;
            last_q     <= 1'b1;
            err_pend_q <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            done_q     <= 1'b0;
            done_id_q  <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 8'h00;
            busy_q     <= 1'b0;
            sclk_q     <= 1'b0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            rx_q       <= rx_d;
            rd_q       <= rd_d;
            cur_q      <= cur_d;
            last_q     <= last_d;
            err_pend_q <= err_pend_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            done_q     <= done_d;
            done_id_q  <= done_id_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            sclk_q     <= sclk_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
        end
    end

    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign busy    = busy_q;
    assign sclk    = sclk_q;
    assign cs      = cs_q;
    assign mosi    = mosi_q;
endmodule
